store_unit: RTL and testbench

- Write-side memory engine for the multicycle RISC-V datapath. The instruction-fetch path only reads Memoria32; this block performs the store direction (sb/sh/sw/sd) into the same 32-bit word memory.
- The control unit pulses START with funct3, address and rs2 data. The block sequences the reads and writes on the Memoria32 port and pulses DONE when the store is complete.
- Sub-word stores use read-modify-write.
- sd issues two word writes: low word first, then high word.

---
 rtl/store_pkg.sv | 38 +++
 rtl/store_unit_if.sv | 27 ++
 rtl/byte_merge.sv | 35 +++
 rtl/store_unit.sv | 176 +++++++++++++++++
 tb/tb_store_unit.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_pkg.sv
// Shared definitions for the store unit: FSM state encoding, FUNCT3 store
// opcodes, read-latency counter width and the request legality check.
package store_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WR_LO = 3'd2,
        WR_HI = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    // Wait counter covers read latencies 1..4 (counts 0..3).
    localparam int CNT_W = 2;

    // Illegal opcode or an address not aligned to the access size.
    function automatic logic req_error(input logic [2:0] f3, input logic [2:0] a);
        logic e;
        e = 1'b0;
        if (f3[2]) begin
            e = 1'b1;
        end else begin
            case (f3)
                F3_SH:   e = a[0];
                F3_SW:   e = |a[1:0];
                F3_SD:   e = |a;
                default: e = 1'b0;
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Store unit bus bundle: control-unit request/status and the Memoria32 port.
//   master: control unit + memory side (drives request and MEM_DATAOUT)
//   slave : store unit (drives memory address/data/write and status)
interface store_unit_if;
    logic        START;
    logic [2:0]  FUNCT3;
    logic [63:0] ADDR;
    logic [63:0] WDATA;
    logic [31:0] MEM_DATAOUT;
    logic [31:0] MEM_RADDR;
    logic [31:0] MEM_WADDR;
    logic [31:0] MEM_DATAIN;
    logic        MEM_WR;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    modport master (
        output START, FUNCT3, ADDR, WDATA, MEM_DATAOUT,
        input  MEM_RADDR, MEM_WADDR, MEM_DATAIN, MEM_WR, BUSY, DONE, ERR
    );

    modport slave (
        input  START, FUNCT3, ADDR, WDATA, MEM_DATAOUT,
        output MEM_RADDR, MEM_WADDR, MEM_DATAIN, MEM_WR, BUSY, DONE, ERR
    );
endinterface

// File: rtl/byte_merge.sv
// Combinational sub-word merge for read-modify-write stores.
//   old_word : word read back from memory
//   data     : store data (byte in [7:0], halfword in [15:0])
//   lane     : byte address within the word (little-endian)
//   is_half  : 1 = halfword store (lane[1] selects half), 0 = byte store
//   merged   : old_word with the addressed lane replaced
module byte_merge (
    input  logic [31:0] old_word,
    input  logic [15:0] data,
    input  logic [1:0]  lane,
    input  logic        is_half,
    output logic [31:0] merged
);

    // Replace the addressed byte or halfword lane.
    always_comb begin
        merged = old_word;
        if (is_half) begin
            if (lane[1]) begin
                merged[31:16] = data;
            end else begin
                merged[15:0] = data;
            end
        end else begin
            case (lane)
                2'd0:    merged[7:0]   = data[7:0];
                2'd1:    merged[15:8]  = data[7:0];
                2'd2:    merged[23:16] = data[7:0];
                2'd3:    merged[31:24] = data[7:0];
                default: merged        = old_word;
            endcase
        end
    end

endmodule

// File: rtl/store_unit.sv
// Store engine for the multicycle RISC-V datapath: sequences sb/sh/sw/sd
// into the 32-bit Memoria32 port (read-modify-write for sub-word stores,
// two word writes for sd) and pulses DONE (with ERR) on completion.
//   CLK, RESET : clock and synchronous active-high reset
//   bus        : store_unit_if.slave (request, status, Memoria32 port)
//   RD_LAT     : cycles from MEM_RADDR to valid MEM_DATAOUT (1..4)
// All outputs are registered; they are computed from the next state so
// that each output register lines up with the state it belongs to.
module store_unit
    import store_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input logic         CLK,
    input logic         RESET,
    store_unit_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    state_e           state_q, state_d;
    logic [2:0]       f3_q, f3_d;
    logic [31:0]      addr_q, addr_d;
    logic [63:0]      wdata_q, wdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      old_word_q, old_word_d;
    logic [31:0]      raddr_q, raddr_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [31:0]      din_q, din_d;
    logic             wr_q, wr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_out_q, err_out_d;
    logic [31:0]      wa_d;
    logic [31:0]      merged_s;
    logic             unused_addr_hi_s;

    assign unused_addr_hi_s = ^bus.ADDR[63:32];

    byte_merge u_merge (
        .old_word (old_word_d),
        .data     (wdata_d[15:0]),
        .lane     (addr_d[1:0]),
        .is_half  (f3_d == F3_SH),
        .merged   (merged_s)
    );

    // Next-state, request capture and next-output computation.
    always_comb begin
        state_d    = state_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        old_word_d = old_word_q;

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    f3_d    = bus.FUNCT3;
                    addr_d  = bus.ADDR[31:0];
                    wdata_d = bus.WDATA;
                    err_d   = req_error(bus.FUNCT3, bus.ADDR[2:0]);
                    cnt_d   = {CNT_W{1'b0}};
                    if (err_d) begin
                        state_d = DONE;
                    end else if (bus.FUNCT3 == F3_SW || bus.FUNCT3 == F3_SD) begin
                        state_d = WR_LO;
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                // Read data is taken on the last READ cycle only.
                if (cnt_q == CNT_LAST) begin
                    old_word_d = bus.MEM_DATAOUT;
                    state_d    = WR_LO;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            WR_LO: begin
                if (f3_q == F3_SD) begin
                    state_d = WR_HI;
                end else begin
                    state_d = DONE;
                end
            end
            WR_HI:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        wa_d      = {addr_d[31:2], 2'b00};
        raddr_d   = 32'd0;
        waddr_d   = 32'd0;
        din_d     = 32'd0;
        wr_d      = 1'b0;
        done_d    = 1'b0;
        err_out_d = 1'b0;
        busy_d    = (state_d != IDLE);

        case (state_d)
            READ: raddr_d = wa_d;
            WR_LO: begin
                wr_d    = 1'b1;
                waddr_d = wa_d;
                // sw/sd have FUNCT3[1] set; sb/sh use the merged word.
                if (f3_d[1]) begin
                    din_d = wdata_d[31:0];
                end else begin
                    din_d = merged_s;
                end
            end
            WR_HI: begin
                wr_d    = 1'b1;
                waddr_d = wa_d + 32'd4;
                din_d   = wdata_d[63:32];
            end
            DONE: begin
                done_d    = 1'b1;
                err_out_d = err_d;
            end
            default: raddr_d = 32'd0;
        endcase
    end

    // State, request and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            f3_q       <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 64'd0;
            err_q      <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            old_word_q <= 32'd0;
            raddr_q    <= 32'd0;
            waddr_q    <= 32'd0;
            din_q      <= 32'd0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            f3_q       <= f3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            old_word_q <= old_word_d;
            raddr_q    <= raddr_d;
            waddr_q    <= waddr_d;
            din_q      <= din_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_out_q  <= err_out_d;
        end
    end

    assign bus.MEM_RADDR  = raddr_q;
    assign bus.MEM_WADDR  = waddr_q;
    assign bus.MEM_DATAIN = din_q;
    assign bus.MEM_WR     = wr_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.ERR        = err_out_q;

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: two instances (RD_LAT=1 and RD_LAT=3) share one
// request stream, each with its own 64-word memory model.
module tb_store_unit;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        exp_err;
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_clr;
    logic        start;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;

    logic [31:0] raddr_w [2];
    logic [31:0] waddr_w [2];
    logic [31:0] din_w   [2];
    logic        wr_w    [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic        err_w   [2];
    logic [31:0] dout_r  [2];
    logic [31:0] apipe1  [2];
    logic [31:0] apipe2  [2];
    logic [31:0] env_mem [2][64];
    logic [31:0] exp_mem [64];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        store_unit_if ifc ();
        assign ifc.START       = start;
        assign ifc.FUNCT3      = f3;
        assign ifc.ADDR        = addr;
        assign ifc.WDATA       = wdata;
        assign ifc.MEM_DATAOUT = dout_r[g];
        assign raddr_w[g] = ifc.MEM_RADDR;
        assign waddr_w[g] = ifc.MEM_WADDR;
        assign din_w[g]   = ifc.MEM_DATAIN;
        assign wr_w[g]    = ifc.MEM_WR;
        assign busy_w[g]  = ifc.BUSY;
        assign done_w[g]  = ifc.DONE;
        assign err_w[g]   = ifc.ERR;
        store_unit #(.RD_LAT(g == 0 ? 1 : 3)) dut (
            .CLK   (clk),
            .RESET (rst),
            .bus   (ifc)
        );
    end

    // Memory models: writes land when MEM_WR is seen; read data reflects the
    // address presented RD_LAT cycles earlier (1 for instance 0, 3 for 1).
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (mem_clr) begin
                for (int i = 0; i < 64; i++) env_mem[g][i] <= 32'd0;
            end else if (wr_w[g]) begin
                env_mem[g][waddr_w[g][7:2]] <= din_w[g];
            end
            apipe1[g] <= raddr_w[g];
            apipe2[g] <= apipe1[g];
        end
        dout_r[0] <= env_mem[0][raddr_w[0][7:2]];
        dout_r[1] <= env_mem[1][apipe2[1][7:2]];
    end

    task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (rd_lat inst %0d) got %h expected %h at %0t", nm, g, act, exp, $time);
        end
    endtask

    // Reference model: error rules and write data from plain arithmetic.
    function automatic vec_t model(input logic [2:0] mf3, input logic [31:0] ma, input logic [63:0] mw);
        vec_t v;
        logic [31:0] old;
        int sh;
        v.f3 = mf3; v.addr = ma; v.wdata = mw;
        v.exp_d0 = 32'd0; v.exp_d1 = 32'd0;
        old = exp_mem[ma[7:2]];
        if (mf3 >= 3'd4)                  v.exp_err = 1'b1;
        else if (mf3 == 3'd1)             v.exp_err = (ma % 2 != 0);
        else if (mf3 == 3'd2)             v.exp_err = (ma % 4 != 0);
        else if (mf3 == 3'd3)             v.exp_err = (ma % 8 != 0);
        else                              v.exp_err = 1'b0;
        if (mf3 == 3'd0) begin
            sh = 8 * int'(ma % 4);
            v.exp_d0 = (old & ~(32'hFF << sh)) | ({24'd0, mw[7:0]} << sh);
        end else if (mf3 == 3'd1) begin
            sh = 16 * int'((ma / 2) % 2);
            v.exp_d0 = (old & ~(32'hFFFF << sh)) | ({16'd0, mw[15:0]} << sh);
        end else begin
            v.exp_d0 = mw[31:0];
            v.exp_d1 = mw[63:32];
        end
        return v;
    endfunction

    task automatic drive_noise();
        f3    = 3'($urandom());
        addr  = {$urandom(), $urandom()};
        wdata = {$urandom(), $urandom()};
    endtask

    // Apply one request and check every output cycle-by-cycle until idle.
    task automatic run_req(input vec_t v);
        int lat [2];
        int rdl [2];
        logic [31:0] wa;
        logic sub, is_sd;
        logic e_wr;
        logic [31:0] e_wa, e_din, e_ra;
        rdl[0] = 1; rdl[1] = 3;
        wa    = v.addr & 32'hFFFF_FFFC;
        sub   = (v.f3 == 3'd0) || (v.f3 == 3'd1);
        is_sd = (v.f3 == 3'd3);
        for (int g = 0; g < 2; g++) begin
            if (v.exp_err)          lat[g] = 1;
            else if (v.f3 == 3'd2)  lat[g] = 2;
            else if (is_sd)         lat[g] = 3;
            else                    lat[g] = rdl[g] + 2;
        end
        start = 1'b1;
        f3    = v.f3;
        addr  = {$urandom(), v.addr};
        wdata = v.wdata;
        for (int c = 1; c <= lat[1] + 1; c++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                e_wr = 1'b0; e_wa = 32'd0; e_din = 32'd0; e_ra = 32'd0;
                if (!v.exp_err) begin
                    if (sub && c <= rdl[g]) e_ra = wa;
                    if (c == lat[g] - 1) begin
                        e_wr = 1'b1;
                        e_wa = is_sd ? wa + 32'd4 : wa;
                        e_din = is_sd ? v.exp_d1 : v.exp_d0;
                    end else if (is_sd && c == 1) begin
                        e_wr = 1'b1; e_wa = wa; e_din = v.exp_d0;
                    end
                end
                chk("busy",  g, 64'(busy_w[g]),  64'(c <= lat[g]));
                chk("done",  g, 64'(done_w[g]),  64'(c == lat[g]));
                if (c == lat[g]) chk("err", g, 64'(err_w[g]), 64'(v.exp_err));
                chk("mem_wr",    g, 64'(wr_w[g]),    64'(e_wr));
                chk("mem_waddr", g, 64'(waddr_w[g]), 64'(e_wa));
                chk("mem_datain",g, 64'(din_w[g]),   64'(e_din));
                chk("mem_raddr", g, 64'(raddr_w[g]), 64'(e_ra));
            end
            // Noise on START while busy (and on the DONE->IDLE edge) must be ignored.
            start = (c <= lat[0]) ? 1'($urandom_range(0, 1)) : 1'b0;
            drive_noise();
        end
        if (!v.exp_err) begin
            exp_mem[v.addr[7:2]] = v.exp_d0;
            if (is_sd) exp_mem[v.addr[7:2] + 6'd1] = v.exp_d1;
        end
    endtask

    vec_t tbl [14];

    initial begin
        vec_t v;
        logic [2:0]  rf3;
        logic [31:0] ra;

        tbl[0]  = '{3'b010, 32'h0000_0010, 64'hCAFEF00D_DEADBEEF, 1'b0, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{3'b011, 32'h0000_0020, 64'h11223344_55667788, 1'b0, 32'h55667788, 32'h11223344};
        tbl[2]  = '{3'b010, 32'h0000_0030, 64'h99999999_AABBCCDD, 1'b0, 32'hAABBCCDD, 32'h0};
        tbl[3]  = '{3'b000, 32'h0000_0033, 64'hFFFFFFFF_FFFFFF5A, 1'b0, 32'h5ABBCCDD, 32'h0};
        tbl[4]  = '{3'b010, 32'h0000_0040, 64'h0_01020304,        1'b0, 32'h01020304, 32'h0};
        tbl[5]  = '{3'b001, 32'h0000_0042, 64'h12345678_9ABCBEEF, 1'b0, 32'hBEEF0304, 32'h0};
        tbl[6]  = '{3'b010, 32'h0000_0006, 64'h0_12345678,        1'b1, 32'h0, 32'h0};
        tbl[7]  = '{3'b100, 32'h0000_0010, 64'h0_12345678,        1'b1, 32'h0, 32'h0};
        tbl[8]  = '{3'b001, 32'h0000_0041, 64'h0_0000ABCD,        1'b1, 32'h0, 32'h0};
        tbl[9]  = '{3'b011, 32'h0000_0024, 64'h1_00000002,        1'b1, 32'h0, 32'h0};
        tbl[10] = '{3'b000, 32'h0000_0030, 64'hABCDEF01_23456777, 1'b0, 32'h5ABBCC77, 32'h0};
        tbl[11] = '{3'b001, 32'h0000_0040, 64'h0_00001122,        1'b0, 32'hBEEF1122, 32'h0};
        tbl[12] = '{3'b011, 32'hFFFF_FFF8, 64'hA1A2A3A4_B1B2B3B4, 1'b0, 32'hB1B2B3B4, 32'hA1A2A3A4};
        tbl[13] = '{3'b111, 32'h0000_0000, 64'h0,                 1'b1, 32'h0, 32'h0};

        for (int i = 0; i < 64; i++) exp_mem[i] = 32'd0;
        rst = 1'b1; mem_clr = 1'b1; start = 1'b0;
        f3 = 3'd0; addr = 64'd0; wdata = 64'd0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_busy",  g, 64'(busy_w[g]),  64'd0);
            chk("rst_done",  g, 64'(done_w[g]),  64'd0);
            chk("rst_err",   g, 64'(err_w[g]),   64'd0);
            chk("rst_wr",    g, 64'(wr_w[g]),    64'd0);
            chk("rst_waddr", g, 64'(waddr_w[g]), 64'd0);
            chk("rst_raddr", g, 64'(raddr_w[g]), 64'd0);
            chk("rst_din",   g, 64'(din_w[g]),   64'd0);
        end
        rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_req(tbl[i]);

        // Reset during the WR_HI cycle of an sd; later START must be a no-op.
        start = 1'b1; f3 = 3'b011; addr = 64'h80; wdata = 64'hA5A5A5A5_5A5A5A5A;
        @(negedge clk);
        for (int g = 0; g < 2; g++) chk("sdrst_lo_waddr", g, 64'(waddr_w[g]), 64'h80);
        start = 1'b1; drive_noise();
        @(negedge clk);
        for (int g = 0; g < 2; g++) chk("sdrst_hi_wr", g, 64'(wr_w[g]), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        for (int g = 0; g < 2; g++) begin
            chk("sdrst_busy", g, 64'(busy_w[g]), 64'd0);
            chk("sdrst_done", g, 64'(done_w[g]), 64'd0);
            chk("sdrst_wr",   g, 64'(wr_w[g]),   64'd0);
            chk("sdrst_out",  g, {waddr_w[g], din_w[g] | raddr_w[g]}, 64'd0);
        end
        repeat (2) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                chk("sdrst_quiet_done", g, 64'(done_w[g]), 64'd0);
                chk("sdrst_quiet_wr",   g, 64'(wr_w[g]),   64'd0);
            end
        end
        for (int g = 0; g < 2; g++) chk("sdrst_low_kept", g, 64'(env_mem[g][32]), 64'h5A5A5A5A);
        exp_mem[32] = 32'h5A5A5A5A;
        exp_mem[33] = 32'hA5A5A5A5;

        // Randomized requests against the reference model.
        for (int n = 0; n < 80; n++) begin
            rf3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            ra  = $urandom();
            if ($urandom_range(0, 2) != 0) begin
                if (rf3 == 3'd1) ra[0] = 1'b0;
                if (rf3 == 3'd2) ra[1:0] = 2'b00;
                if (rf3 == 3'd3) ra[2:0] = 3'b000;
            end
            v = model(rf3, ra, {$urandom(), $urandom()});
            run_req(v);
        end

        @(negedge clk);
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 64; i++)
                chk("final_mem", g, 64'(env_mem[g][i]), 64'(exp_mem[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
